cv32e40p_x_wb_arbiter: RTL

- Shares the single register-file write port between the core writeback (WB) stage and results returning over the x-interface result channel.
- The dispatcher already reports results as always accepted. This block therefore buffers x-results in a small in-order FIFO whenever the core owns the write port.
- A starvation counter bounds how long the core may keep the port. When the bound is reached, the block stalls the core WB stage.
- On each x-result register write, the block reports the written address so the dispatcher scoreboard can clear that entry.

---
 rtl/cv32e40p_x_if_pkg.sv | 13 +
 rtl/cv32e40p_x_wb_fifo.sv | 68 ++++++
 rtl/cv32e40p_x_wb_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cv32e40p_x_if_pkg.sv
// Shared types for the x-interface writeback path.
//   x_wb_entry_t : one buffered x-result register write (destination + data).
package cv32e40p_x_if_pkg;

   localparam int X_RF_AW = 5;
   localparam int X_RF_DW = 32;

   typedef struct packed {
      logic [X_RF_AW-1:0] waddr;
      logic [X_RF_DW-1:0] wdata;
   } x_wb_entry_t;

endpackage

// File: rtl/cv32e40p_x_wb_fifo.sv
// In-order buffer for x-result register writes waiting for the RF write port.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : enqueue one entry (ignored when full)
//   i_pop          : dequeue the head entry (ignored when empty)
//   o_full, o_empty, o_count : occupancy status
//   o_head         : oldest entry, valid while o_empty is low
module cv32e40p_x_wb_fifo
   import cv32e40p_x_if_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  x_wb_entry_t                i_data,
   input  logic                       i_pop,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output x_wb_entry_t                o_head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   x_wb_entry_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH-1)) next_ptr = '0;
      else                        next_ptr = ptr + PTR_W'(1);
   endfunction

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: entries are only read when counted as valid.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/cv32e40p_x_wb_arbiter.sv
// Shares the register-file write port between the core WB stage and the
// x-interface result channel. X-results are always accepted while the buffer
// has room; they bypass straight to the RF when the port is free and nothing
// is queued, otherwise they wait in an in-order buffer. A starvation counter
// lets the core win at most MAX_STARVE consecutive cycles against a non-empty
// buffer before the core WB stage is stalled for one cycle.
// Ports:
//   clk_i, rst_ni                         : clock, asynchronous active-low reset
//   core_we_i/_waddr_i/_wdata_i           : core WB write request
//   core_wb_stall_o                       : core must hold and retry its write
//   x_rvalid_i/x_rready_o                 : x-result handshake
//   x_we_i/x_rd_i/x_rdata_i               : x-result payload
//   rf_we_o/rf_waddr_o/rf_wdata_o         : register-file write port
//   x_wb_done_o/x_wb_addr_o               : x-result written (scoreboard clear)
//   buf_count_o                           : buffer occupancy
module cv32e40p_x_wb_arbiter
   import cv32e40p_x_if_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int MAX_STARVE = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       core_we_i,
   input  logic [4:0]                 core_waddr_i,
   input  logic [31:0]                core_wdata_i,
   output logic                       core_wb_stall_o,
   input  logic                       x_rvalid_i,
   output logic                       x_rready_o,
   input  logic                       x_we_i,
   input  logic [4:0]                 x_rd_i,
   input  logic [31:0]                x_rdata_i,
   output logic                       rf_we_o,
   output logic [4:0]                 rf_waddr_o,
   output logic [31:0]                rf_wdata_o,
   output logic                       x_wb_done_o,
   output logic [4:0]                 x_wb_addr_o,
   output logic [$clog2(DEPTH+1)-1:0] buf_count_o
);

   localparam int ST_W = $clog2(MAX_STARVE+1);

   logic [ST_W-1:0] r_starve;
   logic [ST_W-1:0] w_starve_nxt;

   logic        w_full;
   logic        w_empty;
   x_wb_entry_t w_head;
   x_wb_entry_t w_in_entry;
   logic        w_x_write;
   logic        w_push;
   logic        w_pop;

   assign x_rready_o = ~w_full;
   // Results without a register write are consumed by the handshake alone.
   assign w_x_write  = x_rvalid_i & ~w_full & x_we_i;
   assign w_in_entry = '{waddr: x_rd_i, wdata: x_rdata_i};

   cv32e40p_x_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_push  (w_push),
      .i_data  (w_in_entry),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (buf_count_o),
      .o_head  (w_head)
   );

   always_comb begin
      w_push          = 1'b0;
      w_pop           = 1'b0;
      core_wb_stall_o = 1'b0;
      rf_we_o         = core_we_i;
      rf_waddr_o      = core_waddr_i;
      rf_wdata_o      = core_wdata_i;
      x_wb_done_o     = 1'b0;
      x_wb_addr_o     = '0;
      w_starve_nxt    = '0;

      if (!w_empty) begin
         // Queued results keep priority over new arrivals to preserve order.
         w_push = w_x_write;
         if (!core_we_i || (r_starve == ST_W'(MAX_STARVE))) begin
            w_pop           = 1'b1;
            core_wb_stall_o = core_we_i;
            rf_we_o         = 1'b1;
            rf_waddr_o      = w_head.waddr;
            rf_wdata_o      = w_head.wdata;
            x_wb_done_o     = 1'b1;
            x_wb_addr_o     = w_head.waddr;
         end else begin
            w_starve_nxt = r_starve + ST_W'(1);
         end
      end else if (w_x_write) begin
         if (!core_we_i) begin
            rf_we_o     = 1'b1;
            rf_waddr_o  = x_rd_i;
            rf_wdata_o  = x_rdata_i;
            x_wb_done_o = 1'b1;
            x_wb_addr_o = x_rd_i;
         end else begin
            w_push       = 1'b1;
            w_starve_nxt = r_starve + ST_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_starve <= '0;
      else         r_starve <= w_starve_nxt;
   end

   // Hazard check: a core write must never target an rd still queued here.
   logic [DEPTH-1:0] w_rd_hazard;

   for (genvar g = 0; g < DEPTH; g++) begin : g_rd_hazard
      assign w_rd_hazard[g] =
         ((((g + DEPTH) - int'(u_fifo.r_rd_ptr)) % DEPTH) < int'(buf_count_o)) &&
         (u_fifo.r_mem[g].waddr == core_waddr_i);
   end

   a_no_rd_hazard: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(core_we_i && (|w_rd_hazard)))
      else $error("core write targets rd with a pending x-result");

endmodule
